mem_wb_stage: RTL and testbench

Memory stage plus MEM/WB pipeline register of the 5-stage pipelined CPU. It consumes the outputs of the EX/MEM register, performs data-memory loads and stores against an internal word-addressed array, and models a configurable multi-cycle access latency with a counter FSM that stalls upstream stages. Results are registered into MEM/WB outputs and the write-back mux, which drive the register file and the forwarding unit.

---
 rtl/mem_wb_stage.sv | 114 +++++++++++
 tb/tb_mem_wb_stage.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// Memory stage and MEM/WB pipeline register: word-addressed data memory with
// a configurable multi-cycle access latency that stalls the upstream stages.
`timescale 1ns/1ps
module mem_wb_stage #(
    parameter int DEPTH       = 256,
    parameter int MEM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        startin_n,
    input  logic [1:0]  MEM_wb,
    input  logic        MEM_mem_read,
    input  logic        MEM_mem_write,
    input  logic [31:0] MEM_alu_result,
    input  logic [31:0] MEM_forward_b_mux_out,
    input  logic [4:0]  MEM_reg_dst_mux_out,
    output logic        mem_stall,
    output logic        WB_reg_write,
    output logic        WB_mem_to_reg,
    output logic [31:0] WB_read_data,
    output logic [31:0] WB_alu_result,
    output logic [4:0]  WB_reg_dst_mux_out,
    output logic [31:0] WB_write_data,
    output logic        mem_err
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam bit MULTI  = (MEM_LATENCY > 1);
    localparam logic [CNT_W-1:0] CNT_INIT = MULTI ? CNT_W'(MEM_LATENCY - 2) : '0;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic               op, access, misaligned, conflict;
    logic [ADDR_W-1:0]  idx;
    logic [31:0]        mem [DEPTH];

    assign op         = MEM_mem_read | MEM_mem_write;
    assign idx        = MEM_alu_result[ADDR_W+1:2];
    assign misaligned = (MEM_alu_result[1:0] != 2'b00);
    assign conflict   = MEM_mem_read & MEM_mem_write;
    // Any non-stalled edge is a completing edge; the access happens only then.
    assign access     = op & ~mem_stall;

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        mem_stall = 1'b0;
        case (state)
            IDLE: begin
                if (op && MULTI) begin
                    mem_stall = 1'b1;
                    state_nx  = BUSY;
                    cnt_nx    = CNT_INIT;
                end
            end
            BUSY: begin
                if (cnt != '0) begin
                    mem_stall = 1'b1;
                    cnt_nx    = cnt - 1'b1;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!startin_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Array is not reset; a store pending at reset is simply never written.
    always_ff @(posedge clk) begin
        if (startin_n && access && MEM_mem_write)
            mem[idx] <= MEM_forward_b_mux_out;
    end

    always_ff @(posedge clk) begin
        if (!startin_n) begin
            WB_reg_write       <= 1'b0;
            WB_mem_to_reg      <= 1'b0;
            WB_read_data       <= '0;
            WB_alu_result      <= '0;
            WB_reg_dst_mux_out <= '0;
            mem_err            <= 1'b0;
        end else begin
            if (mem_stall) begin
                WB_reg_write       <= 1'b0;
                WB_mem_to_reg      <= 1'b0;
                WB_read_data       <= '0;
                WB_alu_result      <= '0;
                WB_reg_dst_mux_out <= '0;
            end else begin
                WB_reg_write       <= MEM_wb[1];
                WB_mem_to_reg      <= MEM_wb[0];
                WB_read_data       <= (access && MEM_mem_read && !MEM_mem_write) ? mem[idx] : '0;
                WB_alu_result      <= MEM_alu_result;
                WB_reg_dst_mux_out <= MEM_reg_dst_mux_out;
            end
            if (access && (conflict || misaligned))
                mem_err <= 1'b1;
        end
    end

    assign WB_write_data = WB_mem_to_reg ? WB_read_data : WB_alu_result;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: three instances at latencies 1, 3 and 4, driven by
// vector tables through a scoreboard queue plus hand-written reset sequences.
`timescale 1ns/1ps
module tb_mem_wb_stage;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [1:0]  wb;
        logic [31:0] addr;
        logic [31:0] data;
        logic [4:0]  dst;
        logic [31:0] exp;
        logic        err;
    } vec_t;

    typedef struct packed {
        logic        stall;
        logic        rw;
        logic        m2r;
        logic [31:0] rdata;
        logic [31:0] alu;
        logic [4:0]  dst;
        logic [31:0] wdata;
        logic        err;
    } out_t;

    logic        clk = 1'b0;
    logic        rst_n [3];
    logic [1:0]  wb_i  [3];
    logic        rd_i  [3];
    logic        wr_i  [3];
    logic [31:0] alu_i [3];
    logic [31:0] dat_i [3];
    logic [4:0]  dst_i [3];
    out_t        o     [3];

    int lat_of [3] = '{1, 3, 4};
    int n_vec = 0;
    int n_err = 0;
    vec_t q [$];
    vec_t tab0 [9];
    vec_t tab1 [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int L = (g == 0) ? 1 : (g == 1) ? 3 : 4;
        logic        s, rw, m2r, err;
        logic [31:0] rdata, alu, wdata;
        logic [4:0]  dst;
        mem_wb_stage #(.DEPTH(256), .MEM_LATENCY(L)) dut (
            .clk                   (clk),
            .startin_n             (rst_n[g]),
            .MEM_wb                (wb_i[g]),
            .MEM_mem_read          (rd_i[g]),
            .MEM_mem_write         (wr_i[g]),
            .MEM_alu_result        (alu_i[g]),
            .MEM_forward_b_mux_out (dat_i[g]),
            .MEM_reg_dst_mux_out   (dst_i[g]),
            .mem_stall             (s),
            .WB_reg_write          (rw),
            .WB_mem_to_reg         (m2r),
            .WB_read_data          (rdata),
            .WB_alu_result         (alu),
            .WB_reg_dst_mux_out    (dst),
            .WB_write_data         (wdata),
            .mem_err               (err)
        );
        assign o[g] = {s, rw, m2r, rdata, alu, dst, wdata, err};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input int k, input vec_t v);
        rd_i[k]  = v.rd;
        wr_i[k]  = v.wr;
        wb_i[k]  = v.wb;
        alu_i[k] = v.addr;
        dat_i[k] = v.data;
        dst_i[k] = v.dst;
    endtask

    task automatic chk_zero(input string tag, input int k);
        chk({tag, ".rw"},    32'(o[k].rw),    0);
        chk({tag, ".m2r"},   32'(o[k].m2r),   0);
        chk({tag, ".rdata"}, o[k].rdata,      0);
        chk({tag, ".alu"},   o[k].alu,        0);
        chk({tag, ".dst"},   32'(o[k].dst),   0);
        chk({tag, ".err"},   32'(o[k].err),   0);
    endtask

    // Present one instruction, hold it through any stall, then check the
    // completing edge against the scoreboard entry.
    task automatic run_op(input string tag, input int k, input vec_t v);
        int   stalls;
        int   exp_st;
        bit   done;
        logic st;
        vec_t e;
        drive(k, v);
        q.push_back(v);
        stalls = 0;
        done   = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            #1;
            st = o[k].stall;
            @(posedge clk);
            #1;
            if (st) begin
                stalls++;
                chk({tag, ".bubble_rw"},    32'(o[k].rw), 0);
                chk({tag, ".bubble_wdata"}, o[k].wdata,   0);
            end else begin
                done = 1'b1;
            end
        end
        e = q.pop_front();
        if (!done) begin
            n_vec++;
            n_err++;
            $display("FAIL %s.timeout: got no completion, expected one within 20 cycles", tag);
        end else begin
            exp_st = (e.rd | e.wr) ? lat_of[k] - 1 : 0;
            chk({tag, ".stalls"}, 32'(stalls),   32'(exp_st));
            chk({tag, ".rw"},     32'(o[k].rw),  32'(e.wb[1]));
            chk({tag, ".m2r"},    32'(o[k].m2r), 32'(e.wb[0]));
            chk({tag, ".dst"},    32'(o[k].dst), 32'(e.dst));
            chk({tag, ".alu"},    o[k].alu,      e.addr);
            chk({tag, ".wdata"},  o[k].wdata,    e.exp);
            chk({tag, ".rdata"},  o[k].rdata,    e.wb[0] ? e.exp : 32'h0);
            chk({tag, ".err"},    32'(o[k].err), 32'(e.err));
        end
    endtask

    initial begin
        //          rd    wr    wb     addr          data          dst  exp           err
        tab0 = '{
            '{1'b0, 1'b1, 2'b00, 32'h0000_0010, 32'hDEAD_BEEF, 5'd0,  32'h0000_0010, 1'b0},
            '{1'b1, 1'b0, 2'b11, 32'h0000_0010, 32'h0,         5'd5,  32'hDEAD_BEEF, 1'b0},
            '{1'b0, 1'b0, 2'b10, 32'h0000_0055, 32'h0,         5'd3,  32'h0000_0055, 1'b0},
            '{1'b0, 1'b1, 2'b00, 32'h0000_0040, 32'h1111_1111, 5'd0,  32'h0000_0040, 1'b0},
            '{1'b0, 1'b1, 2'b00, 32'h0000_0004, 32'h0BAD_C0DE, 5'd0,  32'h0000_0004, 1'b0},
            '{1'b1, 1'b1, 2'b01, 32'h0000_0008, 32'hCAFE_F00D, 5'd7,  32'h0,         1'b1},
            '{1'b1, 1'b0, 2'b11, 32'h0000_0006, 32'h0,         5'd9,  32'h0BAD_C0DE, 1'b1},
            '{1'b1, 1'b0, 2'b11, 32'h0000_0008, 32'h0,         5'd10, 32'hCAFE_F00D, 1'b1},
            '{1'b1, 1'b0, 2'b11, 32'h0000_0408, 32'h0,         5'd11, 32'hCAFE_F00D, 1'b1}
        };
        tab1 = '{
            '{1'b0, 1'b1, 2'b00, 32'h0000_0020, 32'h1234_5678, 5'd0,  32'h0000_0020, 1'b0},
            '{1'b1, 1'b0, 2'b11, 32'h0000_0020, 32'h0,         5'd6,  32'h1234_5678, 1'b0},
            '{1'b0, 1'b0, 2'b10, 32'h0000_0055, 32'h0,         5'd2,  32'h0000_0055, 1'b0}
        };

        for (int k = 0; k < 3; k++) begin
            rst_n[k] = 1'b0;
            drive(k, '0);
        end
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk_zero("init", k);
            chk("init.stall", 32'(o[k].stall), 0);
            rst_n[k] = 1'b1;
        end

        // Latency 1: vector table, then reset with a store held active.
        for (int i = 0; i < 9; i++)
            run_op($sformatf("l1.v%0d", i), 0, tab0[i]);
        drive(0, '{1'b0, 1'b1, 2'b11, 32'h40, 32'hFFFF_FFFF, 5'd1, 32'h0, 1'b0});
        rst_n[0] = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            chk_zero("l1.rst", 0);
            chk("l1.rst.stall", 32'(o[0].stall), 0);
        end
        rst_n[0] = 1'b1;
        run_op("l1.after_rst", 0,
               '{1'b1, 1'b0, 2'b11, 32'h40, 32'h0, 5'd12, 32'h1111_1111, 1'b0});

        // Latency 3: table, then reset with a load held (stall stays high in IDLE).
        for (int i = 0; i < 3; i++)
            run_op($sformatf("l3.v%0d", i), 1, tab1[i]);
        drive(1, tab1[1]);
        rst_n[1] = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            chk_zero("l3.rst", 1);
            chk("l3.rst.stall", 32'(o[1].stall), 1);
        end
        rst_n[1] = 1'b1;
        run_op("l3.after_rst", 1, tab1[1]);

        // Latency 4: reset in the second stall cycle drops the pending store.
        run_op("l4.pre", 2,
               '{1'b0, 1'b1, 2'b00, 32'h40, 32'h0F0F_0F0F, 5'd0, 32'h40, 1'b0});
        drive(2, '{1'b0, 1'b1, 2'b00, 32'h40, 32'hA5A5_A5A5, 5'd0, 32'h0, 1'b0});
        #1;
        chk("l4.stall1", 32'(o[2].stall), 1);
        @(posedge clk);
        #1;
        chk("l4.stall2", 32'(o[2].stall), 1);
        chk("l4.stall2.rw", 32'(o[2].rw), 0);
        rst_n[2] = 1'b0;
        drive(2, '0);
        @(posedge clk);
        #1;
        chk("l4.rst.stall", 32'(o[2].stall), 0);
        chk_zero("l4.rst", 2);
        rst_n[2] = 1'b1;
        run_op("l4.load", 2,
               '{1'b1, 1'b0, 2'b11, 32'h40, 32'h0, 5'd4, 32'h0F0F_0F0F, 1'b0});

        for (int k = 0; k < 3; k++)
            drive(k, '0);
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
